// File: rtl/sb_init_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sb_init_sequencer_pkg
// Shared sideband definitions for the SBINIT clock-pattern exchange:
//   - LTSM state encodings (also used by the sideband pattern detector)
//   - default transmitted clock-pattern word
//   - sequencer FSM state enum
//   - helper that tells whether the LTSM state keeps the exchange alive
// -----------------------------------------------------------------------------
package sb_init_sequencer_pkg;

   localparam logic [2:0] LTSM_RESET  = 3'd0;
   localparam logic [2:0] LTSM_SBINIT = 3'd1;

   // bit63 = 1, adjacent bits alternate
   localparam logic [63:0] SB_PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PATTERN = 3'd1,
      ST_GAP     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TOUT    = 3'd4
   } sbinit_state_t;

   // Pattern exchange runs only while the LTSM sits in RESET or SBINIT.
   function automatic logic ltsm_in_scope(input logic [2:0] ltsm_state);
      return (ltsm_state == LTSM_RESET) || (ltsm_state == LTSM_SBINIT);
   endfunction

endpackage

// File: rtl/sb_init_sequencer.sv
// -----------------------------------------------------------------------------
// sb_init_sequencer
// Sequences the sideband initialization clock-pattern exchange. Sends the
// pattern word followed by GAP_CYCLES idle cycles per iteration, tracks
// detect events from the pattern detector, and ends with a one-cycle done
// pulse (EXTRA_ITER iterations after the first detect) or a timeout pulse.
//
// Ports:
//   i_clk                      clock
//   i_rst_n                    asynchronous active-low reset
//   i_state[2:0]               LTSM state (0=RESET, 1=SBINIT, others abort)
//   i_start                    local start pulse
//   i_rx_sb_start_pattern      partner pattern seen in RESET (start pulse)
//   i_rx_sb_pattern_samp_done  two good patterns received (detect pulse)
//   i_ser_ready                serializer accepts o_ser_data
//   o_ser_data[63:0]           pattern word while valid, else 0
//   o_ser_valid                word offered to serializer
//   o_busy                     FSM not in IDLE
//   o_sbinit_done              one-cycle pulse, exchange complete
//   o_timeout                  one-cycle pulse, cycle budget exhausted
// All outputs are registered.
// -----------------------------------------------------------------------------
module sb_init_sequencer
   import sb_init_sequencer_pkg::*;
#(
   parameter logic [63:0] PATTERN_WORD   = SB_PATTERN_WORD,
   parameter int          GAP_CYCLES     = 2,
   parameter int          EXTRA_ITER     = 4,
   parameter int          TIMEOUT_CYCLES = 8000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [2:0]  i_state,
   input  logic        i_start,
   input  logic        i_rx_sb_start_pattern,
   input  logic        i_rx_sb_pattern_samp_done,
   input  logic        i_ser_ready,
   output logic [63:0] o_ser_data,
   output logic        o_ser_valid,
   output logic        o_busy,
   output logic        o_sbinit_done,
   output logic        o_timeout
);

   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
   localparam int EXTRA_W = $clog2(EXTRA_ITER + 1);
   localparam int TOUT_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [EXTRA_W-1:0] EXTRA_LAST = EXTRA_W'(EXTRA_ITER - 1);
   localparam logic [TOUT_W-1:0]  TOUT_LAST  = TOUT_W'(TIMEOUT_CYCLES - 1);

   sbinit_state_t        state_reg, state_next;
   logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
   logic [EXTRA_W-1:0]   extra_cnt_reg, extra_cnt_next;
   logic [TOUT_W-1:0]    tout_cnt_reg, tout_cnt_next;
   logic                 det_flag_reg, det_flag_next;

   logic [63:0]          ser_data_next;
   logic                 ser_valid_next, busy_next, done_next, timeout_next;

   logic                 in_scope;
   logic                 active;
   logic                 det_seen;

   assign in_scope = ltsm_in_scope(i_state);
   assign active   = (state_reg == ST_PATTERN) || (state_reg == ST_GAP);
   // A detect on the iteration-ending cycle still counts for that iteration.
   assign det_seen = det_flag_reg | i_rx_sb_pattern_samp_done;

   // State and counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= ST_IDLE;
         gap_cnt_reg   <= '0;
         extra_cnt_reg <= '0;
         tout_cnt_reg  <= '0;
         det_flag_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         gap_cnt_reg   <= gap_cnt_next;
         extra_cnt_reg <= extra_cnt_next;
         tout_cnt_reg  <= tout_cnt_next;
         det_flag_reg  <= det_flag_next;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_next     = state_reg;
      gap_cnt_next   = gap_cnt_reg;
      extra_cnt_next = extra_cnt_reg;
      tout_cnt_next  = tout_cnt_reg;
      det_flag_next  = det_flag_reg;

      unique case (state_reg)
         ST_IDLE: begin
            if ((i_start || i_rx_sb_start_pattern) && in_scope) begin
               state_next     = ST_PATTERN;
               gap_cnt_next   = '0;
               extra_cnt_next = '0;
               tout_cnt_next  = '0;
               det_flag_next  = 1'b0;
            end
         end
         ST_PATTERN: begin
            if (i_ser_ready) begin
               state_next   = ST_GAP;
               gap_cnt_next = '0;
            end
         end
         ST_GAP: begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = ST_PATTERN;
               if (det_seen) begin
                  extra_cnt_next = extra_cnt_reg + EXTRA_W'(1);
                  if (extra_cnt_reg == EXTRA_LAST)
                     state_next = ST_DONE;
               end
            end
         end
         ST_DONE, ST_TOUT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (active) begin
         tout_cnt_next = tout_cnt_reg + TOUT_W'(1);
         det_flag_next = det_seen;
         // Priority: abort, then done, then timeout.
         if (!in_scope)
            state_next = ST_IDLE;
         else if ((state_next != ST_DONE) && (tout_cnt_reg == TOUT_LAST))
            state_next = ST_TOUT;
      end
   end

   // Output decode from the upcoming state so registered outputs line up
   // with the state they describe.
   always_comb begin
      ser_valid_next = (state_next == ST_PATTERN);
      ser_data_next  = ser_valid_next ? PATTERN_WORD : 64'd0;
      busy_next      = (state_next != ST_IDLE);
      done_next      = (state_next == ST_DONE);
      timeout_next   = (state_next == ST_TOUT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ser_data    <= '0;
         o_ser_valid   <= 1'b0;
         o_busy        <= 1'b0;
         o_sbinit_done <= 1'b0;
         o_timeout     <= 1'b0;
      end else begin
         o_ser_data    <= ser_data_next;
         o_ser_valid   <= ser_valid_next;
         o_busy        <= busy_next;
         o_sbinit_done <= done_next;
         o_timeout     <= timeout_next;
      end
   end

endmodule
